carry_resolve_ctrl: RTL
=======================

# carry_resolve_ctrl

Sequencer that resolves a carry-save pair (sum vector, carry vector) into a binary result by time-sharing one DIGIT_BITS-wide ripple adder over NUM_DIGITS cycles, least-significant digit first. It sits after the squaring/reduction carry-save array, where a full-width carry-propagate adder is too large or too slow. Operands arrive and results leave on valid/ready handshakes, and only one operation is in flight at a time.

## Interface
- DIGIT_BITS, 32, width of the shared adder slice
- NUM_DIGITS, 64, digits per operand; WIDTH = DIGIT_BITS*NUM_DIGITS (2048 by default)
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset; one clock, reset asynchronous and active-low
- in_valid  in  1  operand pair valid
- in_ready  out  1  block can accept an operand pair
- in_sum  in  WIDTH  sum vector
- in_carry  in  WIDTH  carry vector, already aligned (shifted) by the producer
- in_cin  in  1  carry into digit 0
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_result  out  WIDTH  (in_sum + in_carry + in_cin) mod 2^WIDTH
- out_cout  out  1  carry out of bit WIDTH-1

## Operation
- FSM states: IDLE, RUN, DONE. Reset state is IDLE.
- IDLE: in_ready=1. On in_valid&&in_ready:
  - latch in_sum and in_carry into operand registers
  - load in_cin into the carry flop
  - clear digit index to 0
  - go to RUN
- RUN: each cycle adds digit idx of sum, digit idx of carry, and the carry flop through the shared adder.
  - Write the DIGIT_BITS sum into result digit idx.
  - Store the adder carry into the carry flop.
  - idx increments by 1.
  - When idx==NUM_DIGITS-1, the final adder carry goes to out_cout and the FSM goes to DONE.
- DONE: out_valid=1. out_result and out_cout are held stable. On out_ready, go to IDLE.
- Index counter is $clog2(NUM_DIGITS) bits (minimum 1). It never wraps past NUM_DIGITS-1. The value after the last digit is don't-care.
- The result register only changes in RUN. Stale digits from the previous result are visible on out_result while RUN is active. Consumers only sample out_result when out_valid=1.
- in_valid while not IDLE is ignored and not stored; the producer holds it.
- out_ready outside DONE has no effect.
- Reset at any point, including mid-RUN, aborts the operation immediately. Reset values:
  - state=IDLE, in_ready=1, out_valid=0
  - idx=0, carry flop=0
  - out_result=0, out_cout=0
  - operand registers=0
- Arithmetic is unsigned. Overflow beyond WIDTH+1 bits cannot occur, because sum+carry+cin ≤ 2^(WIDTH+1)-1.

## Timing
- Input handshake at edge T0 is followed by RUN at edges T0+1 … T0+NUM_DIGITS. out_valid=1 from the cycle after edge T0+NUM_DIGITS.
- Latency from accept to out_valid is NUM_DIGITS cycles.
- If out_ready=1 when out_valid rises, the output handshake happens at edge T0+NUM_DIGITS+1. in_ready is high in the next cycle, and the next accept is at T0+NUM_DIGITS+2 at the earliest.
- Minimum initiation interval is NUM_DIGITS+2 cycles.
- in_ready and out_valid are decoded from state registers only, with no combinational path from in_valid or out_ready.
- Critical path is one DIGIT_BITS ripple add plus the digit mux. No full-width carry chain exists.

## Structure
- A shared package carry_resolve_pkg holds:
  - the state enum (IDLE, RUN, DONE)
  - the localparam function for index width
- One sub-module, digit_adder:
  - parameterised DIGIT_BITS ripple adder built from the team's existing 1-bit full adder cells
  - ports: a, b, cin → sum, cout
  - purely combinational
- Everything else (FSM, counter, operand/result registers, digit select/write) lives in carry_resolve_ctrl.

## Test plan
- Reset then idle. Hold rst_n=0 for 3 cycles, then release. Required: in_ready=1, out_valid=0, out_result=0, out_cout=0.
- Basic add (DIGIT_BITS=4, NUM_DIGITS=4). Inputs: in_sum=16'h1234, in_carry=16'h0F0F, cin=0. Required: out_valid exactly 4 cycles after accept, out_result=16'h2143, out_cout=0.
- Full ripple (DIGIT_BITS=4, NUM_DIGITS=4). Inputs: in_sum=16'hFFFF, in_carry=16'h0000, cin=1. Required: out_result=16'h0000, out_cout=1. Repeat with in_carry=16'hFFFF, cin=1; required: out_result=16'hFFFF, out_cout=1.
- Backpressure. Hold out_ready=0 for 10 cycles after out_valid. Required: result stable, in_ready=0. Pulse in_valid during this time; required: not accepted. Raise out_ready; required: IDLE next cycle, then the new operand is accepted.
- Reset mid-RUN. Assert rst_n=0 at idx=2. Required: outputs return to reset values asynchronously. A subsequent operation (sum=16'h0001, carry=16'h0001, cin=0) gives 16'h0002.
- Default parameters. Run 1000 random 2048-bit sum/carry/cin triples against a reference model using back-to-back handshakes. Required: every result matches, and the initiation interval is exactly 66 cycles.

Source files
------------

// File: rtl/carry_resolve_pkg.sv
// ============================================================================
//  carry_resolve_pkg
//  Shared types and helpers for the carry-save resolve sequencer.
//  Revision: 1.0
// ============================================================================
`default_nettype none

package carry_resolve_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Digit index width, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/digit_adder.sv
// ============================================================================
//  digit_adder
//  Combinational DIGIT_BITS-wide ripple adder made of 1-bit full adder cells.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module digit_adder #(
  parameter int DIGIT_BITS = 32
) (
  input  logic [DIGIT_BITS-1:0] a,
  input  logic [DIGIT_BITS-1:0] b,
  input  logic                  cin,
  output logic [DIGIT_BITS-1:0] sum,
  output logic                  cout
);

  logic [DIGIT_BITS:0] chain;

  assign chain[0] = cin;

  for (genvar i = 0; i < DIGIT_BITS; i++) begin : g_fa_cell
    assign sum[i]     = a[i] ^ b[i] ^ chain[i];
    assign chain[i+1] = (a[i] & b[i]) | (chain[i] & (a[i] ^ b[i]));
  end

  assign cout = chain[DIGIT_BITS];

endmodule

`default_nettype wire

// File: rtl/carry_resolve_ctrl.sv
// ============================================================================
//  carry_resolve_ctrl
//  Resolves a carry-save pair into binary by reusing one digit adder over
//  NUM_DIGITS cycles, least-significant digit first.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module carry_resolve_ctrl
  import carry_resolve_pkg::*;
#(
  parameter int DIGIT_BITS = 32,
  parameter int NUM_DIGITS = 64
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [DIGIT_BITS*NUM_DIGITS-1:0] in_sum,
  input  logic [DIGIT_BITS*NUM_DIGITS-1:0] in_carry,
  input  logic                             in_cin,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [DIGIT_BITS*NUM_DIGITS-1:0] out_result,
  output logic                             out_cout
);

  localparam int IDX_W = idx_width(NUM_DIGITS);

  state_e                                   state_q, state_d;
  logic [IDX_W-1:0]                         idx_q, idx_d;
  logic                                     carry_q, carry_d;
  logic                                     cout_q, cout_d;
  logic [NUM_DIGITS-1:0][DIGIT_BITS-1:0]    op_sum_q, op_carry_q, result_q;

  logic                  accept;
  logic                  write_en;
  logic                  last_digit;
  logic [DIGIT_BITS-1:0] add_sum;
  logic                  add_cout;

  digit_adder #(
    .DIGIT_BITS(DIGIT_BITS)
  ) u_digit_adder (
    .a    (op_sum_q[idx_q]),
    .b    (op_carry_q[idx_q]),
    .cin  (carry_q),
    .sum  (add_sum),
    .cout (add_cout)
  );

  assign last_digit = (idx_q == IDX_W'(NUM_DIGITS - 1));

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    carry_d  = carry_q;
    cout_d   = cout_q;
    accept   = 1'b0;
    write_en = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          accept  = 1'b1;
          idx_d   = '0;
          carry_d = in_cin;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        write_en = 1'b1;
        carry_d  = add_cout;
        if (last_digit) begin
          cout_d  = add_cout;
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
    end
  end

  // Result digits are written in place; stale digits show until overwritten.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_sum_q   <= '0;
      op_carry_q <= '0;
      result_q   <= '0;
    end else begin
      if (accept) begin
        op_sum_q   <= in_sum;
        op_carry_q <= in_carry;
      end
      if (write_en) result_q[idx_q] <= add_sum;
    end
  end

  assign in_ready   = (state_q == ST_IDLE);
  assign out_valid  = (state_q == ST_DONE);
  assign out_result = result_q;
  assign out_cout   = cout_q;

endmodule

`default_nettype wire
